// File: rtl/jtcop_layermix_if.sv
// Video/CPU bus of the layer mixer: layer pixels and blanking in, rank
// writes from the CPU, and the resolved palette address plus delayed
// blanking out. The mixer uses the slave modport; its driver uses master.
interface jtcop_layermix_if #(
  parameter int LAYERS = 4,
  parameter int PW     = 8,
  parameter int LW     = $clog2(LAYERS)
);
  logic                   pxl_cen;
  logic                   LHBL;
  logic                   LVBL;
  logic [LAYERS*PW-1:0]   pxl_in;
  logic [LAYERS-1:0]      gfx_en;
  logic                   prio_we;
  logic [LW-1:0]          prio_addr;
  logic [LW-1:0]          prio_din;
  logic [LW+PW-1:0]       pal_addr;
  logic                   opaque;
  logic                   LHBL_dly;
  logic                   LVBL_dly;

  modport master (
    output pxl_cen, LHBL, LVBL, pxl_in, gfx_en, prio_we, prio_addr, prio_din,
    input  pal_addr, opaque, LHBL_dly, LVBL_dly
  );

  modport slave (
    input  pxl_cen, LHBL, LVBL, pxl_in, gfx_en, prio_we, prio_addr, prio_din,
    output pal_addr, opaque, LHBL_dly, LVBL_dly
  );
endinterface

// File: rtl/jtcop_layermix.sv
// Layer priority mixer: picks the frontmost opaque layer using
// CPU-programmable ranks. Ranks are double-buffered (pending/active) and
// the active set is refreshed only on vertical blank entry, so each frame
// is drawn with a single consistent priority order. Two-stage pipeline,
// both stages advanced by pxl_cen.
module jtcop_layermix #(
  parameter int LAYERS     = 4,
  parameter int PW         = 8,
  parameter int PENW       = 4,
  parameter int BACK_LAYER = 0,
  parameter int LW         = $clog2(LAYERS)
) (
  input  logic              clk,
  input  logic              rst,
  jtcop_layermix_if.slave   bus
);

  // rank banks and edge detector
  logic [LAYERS-1:0][LW-1:0] active_rank;
  logic                      prev_lvbl_q;
  logic                      copy_en;

  // stage 1
  logic [LAYERS-1:0][PW-1:0] pxl_d;
  logic [LAYERS-1:0][PW-1:0] pxl_q;
  logic [LAYERS-1:0]         opq_d;
  logic [LAYERS-1:0]         opq_q;
  logic                      lhbl_q;
  logic                      lvbl_q;

  // stage 2
  logic [LW+PW-1:0]          pal_addr_d;
  logic [LW+PW-1:0]          pal_addr_q;
  logic                      opaque_d;
  logic                      opaque_q;
  logic                      lhbl_dly_q;
  logic                      lvbl_dly_q;

  // winner search
  logic                      found;
  logic [LW-1:0]             win_idx;
  logic [LW-1:0]             win_rank;
  logic [PW-1:0]             win_pxl;

  // Copy fires on the clk edge where LVBL is seen low after being high.
  assign copy_en = prev_lvbl_q & ~bus.LVBL;

  // Track LVBL every clk, independent of the pixel enable
  always_ff @(posedge clk) begin
    if (rst) prev_lvbl_q <= 1'b0;
    else     prev_lvbl_q <= bus.LVBL;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_layer
      logic [LW-1:0] pending_q;
      logic [LW-1:0] active_q;
      logic          wr_hit;

      // Addresses at or above LAYERS never match any entry, so they are dropped.
      assign wr_hit = bus.prio_we && (bus.prio_addr == LW'(gi));

      assign pxl_d[gi]       = bus.pxl_in[gi*PW +: PW];
      assign opq_d[gi]       = bus.gfx_en[gi] && (pxl_d[gi][PENW-1:0] != '0);
      assign active_rank[gi] = active_q;

      // Rank storage; a write on the copy edge goes straight through to active
      always_ff @(posedge clk) begin
        if (rst) begin
          pending_q <= LW'(gi);
          active_q  <= LW'(gi);
        end else begin
          if (wr_hit) pending_q <= bus.prio_din;
          if (copy_en) active_q <= wr_hit ? bus.prio_din : pending_q;
        end
      end
    end
  endgenerate

  // Stage 1: capture pixels, opacity and blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_q  <= '0;
      opq_q  <= '0;
      lhbl_q <= 1'b0;
      lvbl_q <= 1'b0;
    end else if (bus.pxl_cen) begin
      pxl_q  <= pxl_d;
      opq_q  <= opq_d;
      lhbl_q <= bus.LHBL;
      lvbl_q <= bus.LVBL;
    end
  end

  // Resolve the frontmost opaque layer; >= lets higher indices win ties
  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    win_rank   = '0;
    win_pxl    = '0;
    pal_addr_d = '0;
    opaque_d   = 1'b0;
    for (int i = 0; i < LAYERS; i++) begin
      if (opq_q[i] && (!found || active_rank[i] >= win_rank)) begin
        found    = 1'b1;
        win_idx  = LW'(i);
        win_rank = active_rank[i];
        win_pxl  = pxl_q[i];
      end
    end
    if (lhbl_q && lvbl_q) begin
      if (found) begin
        pal_addr_d = {win_idx, win_pxl};
        opaque_d   = 1'b1;
      end else begin
        pal_addr_d = {LW'(BACK_LAYER), {PW{1'b0}}};
      end
    end
  end

  // Stage 2: register mixer result and delayed blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_addr_q <= '0;
      opaque_q   <= 1'b0;
      lhbl_dly_q <= 1'b0;
      lvbl_dly_q <= 1'b0;
    end else if (bus.pxl_cen) begin
      pal_addr_q <= pal_addr_d;
      opaque_q   <= opaque_d;
      lhbl_dly_q <= lhbl_q;
      lvbl_dly_q <= lvbl_q;
    end
  end

  assign bus.pal_addr = pal_addr_q;
  assign bus.opaque   = opaque_q;
  assign bus.LHBL_dly = lhbl_dly_q;
  assign bus.LVBL_dly = lvbl_dly_q;

endmodule

// File: tb/tb_jtcop_layermix.sv
// Directed bench for jtcop_layermix (LAYERS=4, PW=8, BACK_LAYER=0).
// Layer pixels used: layer3=A4, layer2=B3, layer1=C2, layer0=D1.
module tb_jtcop_layermix;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  localparam logic [31:0] ALL_OP  = 32'hA4B3C2D1;
  localparam logic [31:0] L3_TR   = 32'hA0B3C2D1;
  localparam logic [31:0] ALL_TR  = 32'hA0B0C0D0;

  jtcop_layermix_if #(.LAYERS(4), .PW(8)) bus ();

  jtcop_layermix #(.LAYERS(4), .PW(8), .PENW(4), .BACK_LAYER(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // one clk cycle with the given pixel enable
  task automatic tick(input logic cen);
    bus.pxl_cen = cen;
    @(posedge clk);
    #1;
    bus.pxl_cen = 1'b0;
  endtask

  // push one pixel through both pipeline stages
  task automatic run_pix(input logic [31:0] pix, input logic [3:0] en);
    bus.pxl_in = pix;
    bus.gfx_en = en;
    tick(1'b1);
    tick(1'b1);
    $display("pix in=%h en=%b lhbl=%b lvbl=%b -> pal=%h op=%b", pix, en,
             bus.LHBL, bus.LVBL, bus.pal_addr, bus.opaque);
  endtask

  task automatic prio_write(input logic [1:0] addr, input logic [1:0] din);
    bus.prio_we   = 1'b1;
    bus.prio_addr = addr;
    bus.prio_din  = din;
    tick(1'b0);
    bus.prio_we   = 1'b0;
    $display("rank write layer=%0d rank=%0d", addr, din);
  endtask

  task automatic vblank_pulse();
    bus.LVBL = 1'b0;
    tick(1'b0);
    tick(1'b0);
    bus.LVBL = 1'b1;
    tick(1'b0);
    $display("vblank pulse");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    checks++; if (bus.pal_addr !== 10'h000) begin errors++; $display("FAIL reset_pal got=%h want=000", bus.pal_addr); end
    checks++; if (bus.opaque !== 1'b0) begin errors++; $display("FAIL reset_opaque got=%b want=0", bus.opaque); end
    checks++; if ({bus.LHBL_dly, bus.LVBL_dly} !== 2'b00) begin errors++; $display("FAIL reset_blank got=%b want=00", {bus.LHBL_dly, bus.LVBL_dly}); end
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h3A4) begin errors++; $display("FAIL default_front got=%h want=3a4", bus.pal_addr); end
    checks++; if (bus.opaque !== 1'b1) begin errors++; $display("FAIL default_opaque got=%b want=1", bus.opaque); end
    checks++; if ({bus.LHBL_dly, bus.LVBL_dly} !== 2'b11) begin errors++; $display("FAIL default_blank got=%b want=11", {bus.LHBL_dly, bus.LVBL_dly}); end
  endtask

  task automatic test_opacity();
    run_pix(L3_TR, 4'hF);
    checks++; if (bus.pal_addr !== 10'h2B3) begin errors++; $display("FAIL pen0_layer3 got=%h want=2b3", bus.pal_addr); end
    run_pix(L3_TR, 4'b0011);
    checks++; if (bus.pal_addr !== 10'h1C2) begin errors++; $display("FAIL gfx_en_mask got=%h want=1c2", bus.pal_addr); end
    run_pix(ALL_TR, 4'hF);
    checks++; if (bus.pal_addr !== 10'h000 || bus.opaque !== 1'b0) begin errors++; $display("FAIL backdrop got=%h/%b want=000/0", bus.pal_addr, bus.opaque); end
    checks++; if (bus.LHBL_dly !== 1'b1) begin errors++; $display("FAIL backdrop_lhbl got=%b want=1", bus.LHBL_dly); end
  endtask

  task automatic test_rank_swap();
    prio_write(2'd0, 2'd3);
    prio_write(2'd3, 2'd0);
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h3A4) begin errors++; $display("FAIL swap_pending got=%h want=3a4", bus.pal_addr); end
    bus.LVBL = 1'b0;
    tick(1'b0);
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h000 || bus.opaque !== 1'b0 || bus.LVBL_dly !== 1'b0) begin
      errors++; $display("FAIL vblank_out got=%h/%b/%b want=000/0/0", bus.pal_addr, bus.opaque, bus.LVBL_dly); end
    bus.LVBL = 1'b1;
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h0D1) begin errors++; $display("FAIL swap_applied got=%h want=0d1", bus.pal_addr); end
  endtask

  task automatic test_equal_ranks();
    prio_write(2'd0, 2'd2);
    prio_write(2'd1, 2'd2);
    prio_write(2'd2, 2'd2);
    // write to layer 3 lands on the very edge LVBL falls
    bus.LVBL      = 1'b0;
    bus.prio_we   = 1'b1;
    bus.prio_addr = 2'd3;
    bus.prio_din  = 2'd2;
    tick(1'b0);
    bus.prio_we   = 1'b0;
    $display("rank write layer=3 rank=2 on vblank edge");
    tick(1'b0);
    bus.LVBL = 1'b1;
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h3A4) begin errors++; $display("FAIL edge_write got=%h want=3a4", bus.pal_addr); end
    run_pix(L3_TR, 4'hF);
    checks++; if (bus.pal_addr !== 10'h2B3) begin errors++; $display("FAIL tie_high_index got=%h want=2b3", bus.pal_addr); end
    run_pix(L3_TR, 4'b0011);
    checks++; if (bus.pal_addr !== 10'h1C2) begin errors++; $display("FAIL tie_masked got=%h want=1c2", bus.pal_addr); end
  endtask

  task automatic test_blank_freeze();
    bus.pxl_in = ALL_OP;
    bus.gfx_en = 4'hF;
    bus.LHBL = 1'b1;
    tick(1'b1);
    bus.LHBL = 1'b0;
    tick(1'b1);
    checks++; if (bus.pal_addr !== 10'h3A4 || bus.LHBL_dly !== 1'b1) begin
      errors++; $display("FAIL pre_hblank got=%h/%b want=3a4/1", bus.pal_addr, bus.LHBL_dly); end
    bus.LHBL = 1'b1;
    tick(1'b1);
    checks++; if (bus.pal_addr !== 10'h000 || bus.opaque !== 1'b0 || bus.LHBL_dly !== 1'b0) begin
      errors++; $display("FAIL hblank got=%h/%b/%b want=000/0/0", bus.pal_addr, bus.opaque, bus.LHBL_dly); end
    tick(1'b1);
    checks++; if (bus.pal_addr !== 10'h3A4 || bus.LHBL_dly !== 1'b1) begin
      errors++; $display("FAIL post_hblank got=%h/%b want=3a4/1", bus.pal_addr, bus.LHBL_dly); end
    bus.pxl_in = L3_TR;
    for (int k = 0; k < 5; k++) tick(1'b0);
    checks++; if (bus.pal_addr !== 10'h3A4 || bus.opaque !== 1'b1) begin
      errors++; $display("FAIL freeze got=%h/%b want=3a4/1", bus.pal_addr, bus.opaque); end
    tick(1'b1);
    checks++; if (bus.pal_addr !== 10'h3A4) begin errors++; $display("FAIL freeze_stage1 got=%h want=3a4", bus.pal_addr); end
    tick(1'b1);
    checks++; if (bus.pal_addr !== 10'h2B3) begin errors++; $display("FAIL resume got=%h want=2b3", bus.pal_addr); end
    $display("blank/freeze sequence done");
  endtask

  task automatic test_reset_mid();
    prio_write(2'd0, 2'd3);
    prio_write(2'd3, 2'd0);
    vblank_pulse();
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h0D1) begin errors++; $display("FAIL custom_ranks got=%h want=0d1", bus.pal_addr); end
    // pending change that must be discarded by reset
    prio_write(2'd0, 2'd0);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    checks++; if (bus.pal_addr !== 10'h000 || bus.opaque !== 1'b0 || {bus.LHBL_dly, bus.LVBL_dly} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_flush got=%h/%b/%b want=000/0/00", bus.pal_addr, bus.opaque, {bus.LHBL_dly, bus.LVBL_dly}); end
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h3A4) begin errors++; $display("FAIL reset_ranks got=%h want=3a4", bus.pal_addr); end
    vblank_pulse();
    run_pix(ALL_OP, 4'hF);
    checks++; if (bus.pal_addr !== 10'h3A4) begin errors++; $display("FAIL pending_lost got=%h want=3a4", bus.pal_addr); end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.pxl_cen   = 1'b0;
    bus.LHBL      = 1'b1;
    bus.LVBL      = 1'b1;
    bus.pxl_in    = '0;
    bus.gfx_en    = 4'hF;
    bus.prio_we   = 1'b0;
    bus.prio_addr = '0;
    bus.prio_din  = '0;
    test_reset();
    test_opacity();
    test_rank_swap();
    test_equal_ranks();
    test_blank_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtcop_layermix.md
# jtcop_layermix

Parametrised layer priority mixer for the JTCOP video path. It takes N tile/object layer pixels and resolves the frontmost opaque one using CPU-programmable per-layer ranks, then emits a palette address plus delayed blanking. The block sits between the layer generators and palette/colour output, and replaces a fixed three-layer PROM priority. Rank writes are double-buffered and applied only on vertical blank entry, so a frame never mixes two priority orders.

## Interface
Parameters:
- LAYERS, 4, number of input layers (2..8)
- PW, 8, pixel width per layer (palette bank + pen)
- PENW, 4, low pixel bits forming the pen; pen 0 is transparent
- BACK_LAYER, 0, layer index used for the backdrop address
- LW, $clog2(LAYERS), layer index / rank width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pxl_cen  in  1  pixel clock enable; every pipeline advance is qualified by it
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- pxl_in  in  LAYERS*PW  layer pixels, layer i at bits [i*PW +: PW]
- gfx_en  in  LAYERS  debug layer enable, 0 forces layer i transparent
- prio_we  in  1  rank write strobe, one clk cycle
- prio_addr  in  LW  layer whose rank is written
- prio_din  in  LW  new rank; higher rank is drawn in front
- pal_addr  out  LW+PW  {winning layer, winning pixel}
- opaque  out  1  1 when some layer won, 0 for backdrop/blank
- LHBL_dly  out  1  LHBL delayed to align with pal_addr
- LVBL_dly  out  1  LVBL delayed to align with pal_addr

## Operation
- Two rank banks: pending[LAYERS] (written by CPU) and active[LAYERS] (used by mixer).
- A prio_we write updates pending[prio_addr] on the same clk edge, regardless of pxl_cen. prio_addr ≥ LAYERS is ignored.
- Copy pending→active occurs on the clk edge where the registered LVBL falls 1→0, i.e. vblank entry. Edge detection uses LVBL sampled every clk, not gated by pxl_cen.
- If prio_we coincides with the copy edge, the new write is included in the copy (write-through to active for that entry).
- Opacity: layer i is opaque iff gfx_en[i]=1 and pxl_in[i][PENW-1:0]≠0.
- Winner: the opaque layer with the highest active rank. On equal ranks, the higher layer index wins.
- No opaque layer: pal_addr={BACK_LAYER, PW'd0}, opaque=0.
- Blank (LHBL=0 or LVBL=0 at stage 1): pal_addr=0, opaque=0.
- State machine: none beyond the pipeline. Only the copy-edge detector register holds state (prev_lvbl).

## Timing
- Stage 1 (pxl_cen): register pxl_in, the opacity vector, and LHBL/LVBL.
- Stage 2 (pxl_cen): register the winner result into pal_addr/opaque, and LHBL_dly/LVBL_dly.
- Latency: exactly 2 pxl_cen pulses from input to output, identical for data and blanking.
- Outputs hold their value between pxl_cen pulses.
- Reset values:
  - pending[i]=active[i]=i (layer LAYERS-1 frontmost)
  - pal_addr=0, opaque=0, LHBL_dly=0, LVBL_dly=0
  - stage-1 registers 0; prev_lvbl=0
- Reset asserted mid-frame clears the pipeline on the next clk edge and restores default ranks. Pending writes made before reset are lost.
- Because prev_lvbl resets to 0, the first LVBL 1→0 after reset triggers a copy.
- The mixer reads active only. A rank change becomes visible on the first pixel of the frame following the vblank entry.

## Test plan
- Reset, LAYERS=4, all pens nonzero, gfx_en=4'hF -> after 2 pxl_cen, pal_addr={2'd3, pxl_in[3]}, opaque=1; immediately after reset, all outputs 0.
- Layer 3 pen=0, layers 0..2 opaque -> pal_addr layer field=2. Then gfx_en=4'b0011 -> layer field=1. All pens 0 -> pal_addr={BACK_LAYER, 8'h00}, opaque=0.
- Write rank(0)=3 and rank(3)=0 during active display -> output unchanged until vblank entry. From the next frame, layer 0 wins when all layers are opaque.
- Set ranks all equal to 2 -> the highest-index opaque layer wins. Also assert prio_we on the same clk as LVBL falls -> the written value is active in the next frame.
- Toggle LHBL low with opaque pixels present -> pal_addr=0 and LHBL_dly=0 exactly 2 pxl_cen later. pxl_cen held low for 5 clk -> outputs frozen.
- Assert rst mid-line after custom ranks -> next frame uses default ranks (layer 3 front), and the pipeline is flushed to 0.
